polyphase_mac_scheduler: RTL and testbench
==========================================

Name: polyphase_mac_scheduler

Overview:
Controller for the upsampling/filtering stage of the 64QAM modulator. It time-multiplexes one multiply-accumulate slice across all taps and phases of an L-fold polyphase interpolating FIR. For every accepted 4-bit symbol-level sample, it emits L filtered output samples.
The block owns the sample delay line, the coefficient register file, the phase/tap sequencing FSM, and both the input and output valid/ready handshakes.

Parameters:
SAMPLE_W, 4, signed two's-complement input sample width (levels -7..+7 used)
COEF_W, 8, signed two's-complement coefficient width
L, 4, upsampling factor (phases per input sample)
P, 4, taps per phase; total coefficients L*P
ACC_W, 14, accumulator/output width; must be >= SAMPLE_W+COEF_W+clog2(P)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  SAMPLE_W  signed input sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(L*P)  coefficient index k (0..L*P-1)
coef_wdata  in  COEF_W  signed coefficient value
busy  out  1  high whenever the FSM is not in IDLE
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_data  out  ACC_W  signed filtered output sample

Behaviour:
- Reset (async, rst=1): FSM=IDLE; delay line, accumulator, phase and tap counters=0; coefficients=0. Outputs: in_ready=1, busy=0, out_valid=0, out_data=0.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: shift in_data into d[0] (d[i]<=d[i-1], oldest discarded); phase<=0, tap<=0, acc<=0; go to MAC.
- MAC:
  - in_ready=0.
  - Each cycle: acc <= acc + sext(d[tap]) * sext(h[tap*L+phase]); tap++.
  - Exactly P cycles; after the cycle with tap==P-1, go to OUT.
- OUT:
  - out_valid=1; out_data=acc (registered, stable while out_valid=1 and out_ready=0).
  - On out_ready:
    - if phase==L-1, go to IDLE;
    - else phase++, tap<=0, acc<=0, go to MAC.
- Latency:
  - Sample accepted at edge T; first out_valid high in the cycle after edge T+P.
  - With out_ready held high, successive outputs are P+1 cycles apart.
  - Minimum throughput is one input per L*(P+1)+1 cycles.
- Arithmetic:
  - Full-precision signed product; sign-extended to ACC_W.
  - No rounding, no saturation; ACC_W default is exact for the worst case.
- Coefficient writes: h[coef_addr]<=coef_wdata only when coef_we=1 and state==IDLE. Writes while busy=1 are ignored (no queuing).
- Simultaneous events:
  - coef_we and in_valid handshake in the same IDLE cycle: the write happens and the sample is accepted.
  - The MAC sequence for that sample uses the new coefficient.
- in_valid while busy: held off by in_ready=0; the sample must remain presented by upstream.
- out_valid never drops without out_ready.
- Reset asserted mid-MAC or mid-OUT: immediate return to reset values; pending output is lost.

Decomposition:
- Shared package: SAMPLE_W, COEF_W, L, P, ACC_W defaults, and the FSM state encoding (IDLE=0, MAC=1, OUT=2).
- One sub-module, poly_mac_unit: registered signed multiply-accumulate with clear and enable inputs.
- Sequencing, delay line and coefficient file stay in the top block.

Test Plan:
- Reset check: drive rst=1 asynchronously mid-clock → in_ready=1, busy=0, out_valid=0, out_data=0 immediately.
- Impulse response:
  - Load h[k]=k+1 (k=0..15).
  - Send samples 1,0,0,0 with out_ready=1.
  - Outputs in order: 1,2,3,4, then 5,6,7,8, then 9,10,11,12, then 13,14,15,16.
  - Spacing is P+1=5 cycles within a sample.
- Worst-case magnitude: all h=-128, send -8 four times → fourth sample's four outputs each = +4096; no overflow in 14 bits.
- Backpressure: hold out_ready=0 for 3 cycles on the first output → out_valid stays 1 and out_data stays constant; the output is released on the cycle out_ready=1.
- Coefficient write while busy: write h[0]=99 during MAC → ignored. Impulse output phase 0 is still 1; the same write in IDLE then yields 99.
- Reset mid-operation: assert rst during the MAC of phase 2 → no further out_valid. After release, the delay line is zero: sending 0 yields outputs 0,0,0,0.

Source files
------------

// File: rtl/polyphase_mac_scheduler_pkg.sv
// Shared sizing and FSM encoding for the polyphase interpolator MAC scheduler.
package polyphase_mac_scheduler_pkg;

    localparam int SAMPLE_W = 4;
    localparam int COEF_W   = 8;
    localparam int L        = 4;
    localparam int P        = 4;
    localparam int ACC_W    = 14;

    localparam int NCOEF  = L * P;
    localparam int ADDR_W = $clog2(NCOEF);
    localparam int PH_W   = $clog2(L);
    localparam int TAP_W  = $clog2(P);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/polyphase_mac_scheduler_poly_mac_unit.sv
// Registered signed multiply-accumulate slice; clear has priority over enable.
module poly_mac_unit #(
    parameter int A_W   = 4,
    parameter int B_W   = 8,
    parameter int ACC_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [ACC_W-1:0] acc_o
);

    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_d;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/polyphase_mac_scheduler.sv
// L-fold polyphase interpolating FIR controller: one MAC slice swept over taps,
// then phases, for every accepted input sample.
//
// state | meaning
// IDLE  | waiting for an input sample; coefficient writes allowed
// MAC   | accumulating P taps of the current phase, one per cycle
// OUT   | holding the phase result until downstream accepts it
module polyphase_mac_scheduler
    import polyphase_mac_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [SAMPLE_W-1:0] in_data_i,
    input  logic              coef_we_i,
    input  logic [ADDR_W-1:0] coef_addr_i,
    input  logic [COEF_W-1:0] coef_wdata_i,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_data_o
);

    state_t              state_q;
    logic [PH_W-1:0]     phase_q;
    logic [TAP_W-1:0]    tap_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                out_valid_q;
    logic [SAMPLE_W-1:0] dly_q  [P];
    logic [COEF_W-1:0]   coef_q [NCOEF];

    logic              accept;
    logic              out_xfer;
    logic              last_phase;
    logic              last_tap;
    logic              mac_clr;
    logic              mac_en;
    logic [ADDR_W-1:0] coef_idx;

    assign accept     = (state_q == ST_IDLE) && in_valid_i;
    assign out_xfer   = (state_q == ST_OUT) && out_ready_i;
    assign last_phase = (phase_q == PH_W'(L - 1));
    assign last_tap   = (tap_q == TAP_W'(P - 1));
    assign mac_clr    = accept || (out_xfer && !last_phase);
    assign mac_en     = (state_q == ST_MAC);
    // Coefficient k = tap*L + phase belongs to phase (k mod L).
    assign coef_idx   = ADDR_W'(tap_q) * ADDR_W'(L) + ADDR_W'(phase_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            tap_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_MAC;
                        phase_q    <= '0;
                        tap_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_MAC: begin
                    if (last_tap) begin
                        tap_q       <= '0;
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (last_phase) begin
                            state_q    <= ST_IDLE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= ST_MAC;
                            phase_q <= phase_q + 1'b1;
                            tap_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < P; i++) begin
                dly_q[i] <= '0;
            end
        end else if (accept) begin
            dly_q[0] <= in_data_i;
            for (int i = 1; i < P; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // Writes during a sequence are dropped so a filter pass never mixes coefficient sets.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NCOEF; k++) begin
                coef_q[k] <= '0;
            end
        end else if (coef_we_i && (state_q == ST_IDLE)) begin
            coef_q[coef_addr_i] <= coef_wdata_i;
        end
    end

    poly_mac_unit #(
        .A_W   (SAMPLE_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (dly_q[tap_q]),
        .b_i   (coef_q[coef_idx]),
        .acc_o (out_data_o)
    );

    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_polyphase_mac_scheduler.sv
// Self-checking bench: vector table plus corner sequences, outputs scored from a queue.
`timescale 1ns/1ps
module tb_polyphase_mac_scheduler;
    import polyphase_mac_scheduler_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [SAMPLE_W-1:0] in_data_i = '0;
    logic                coef_we_i = 1'b0;
    logic [ADDR_W-1:0]   coef_addr_i = '0;
    logic [COEF_W-1:0]   coef_wdata_i = '0;
    logic                busy_o;
    logic                out_valid_o;
    logic                out_ready_i = 1'b1;
    logic [ACC_W-1:0]    out_data_o;

    polyphase_mac_scheduler dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .coef_we_i    (coef_we_i),
        .coef_addr_i  (coef_addr_i),
        .coef_wdata_i (coef_wdata_i),
        .busy_o       (busy_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: delay line and coefficient file as the bench believes them to be.
    int     dl_m [P];
    int     h_m  [NCOEF];
    longint exp_q[$];

    function automatic longint model_out(input int p);
        longint s = 0;
        for (int t = 0; t < P; t++) s += longint'(dl_m[t]) * longint'(h_m[t*L + p]);
        return s;
    endfunction

    task automatic model_shift(input int s);
        for (int i = P - 1; i > 0; i--) dl_m[i] = dl_m[i-1];
        dl_m[0] = s;
    endtask

    task automatic push_model();
        for (int p = 0; p < L; p++) exp_q.push_back(model_out(p));
    endtask

    // Scoreboard: an output is consumed on the edge following a negedge with valid & ready.
    bit chk_gap   = 1'b0;
    int last_xfer = 0;
    int n_out     = 0;

    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got %0d, expected no output", $signed(out_data_o));
            end else begin
                check("out_data", longint'($signed(out_data_o)), exp_q.pop_front());
            end
            if (chk_gap) check("out_spacing", longint'(cyc + 1 - last_xfer), longint'(P + 1));
            last_xfer = cyc + 1;
            n_out++;
        end
    end

    task automatic wr_coef(input int a, input int v, input bit eff);
        coef_we_i    = 1'b1;
        coef_addr_i  = ADDR_W'(a);
        coef_wdata_i = COEF_W'(v);
        @(posedge clk_i); #1;
        coef_we_i = 1'b0;
        if (eff) h_m[a] = v;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < NCOEF; k++) wr_coef(k, k + 1, 1'b1);
    endtask

    task automatic load_const(input int v);
        for (int k = 0; k < NCOEF; k++) wr_coef(k, v, 1'b1);
    endtask

    task automatic send(input int s, input bit w, input int a, input int v);
        bit rdy;
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i  = SAMPLE_W'(s);
        if (w) begin
            coef_we_i    = 1'b1;
            coef_addr_i  = ADDR_W'(a);
            coef_wdata_i = COEF_W'(v);
        end
        do begin
            rdy = in_ready_o;
            @(posedge clk_i); #1;
            n++;
        end while (!rdy && n < 200);
        in_valid_i = 1'b0;
        coef_we_i  = 1'b0;
        check("accept_timeout", longint'(rdy), 1);
        last_xfer = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("drain_timeout", longint'(exp_q.size()), 0);
        @(posedge clk_i); #1;
    endtask

    typedef struct {
        int smp;
        int cset;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t tbl[10];
    logic [ACC_W-1:0] held;

    initial begin
        // cset: 0 keep, 1 load h[k]=k+1, 2 load all -128
        tbl[0] = '{1, 1, 1, 2, 3, 4};
        tbl[1] = '{0, 0, 5, 6, 7, 8};
        tbl[2] = '{0, 0, 9, 10, 11, 12};
        tbl[3] = '{0, 0, 13, 14, 15, 16};
        tbl[4] = '{-8, 2, 1024, 1024, 1024, 1024};
        tbl[5] = '{-8, 0, 2048, 2048, 2048, 2048};
        tbl[6] = '{-8, 0, 3072, 3072, 3072, 3072};
        tbl[7] = '{-8, 0, 4096, 4096, 4096, 4096};
        tbl[8] = '{2, 1, -214, -236, -258, -280};
        tbl[9] = '{-3, 0, -169, -186, -203, -220};
        for (int i = 0; i < P; i++) dl_m[i] = 0;
        for (int k = 0; k < NCOEF; k++) h_m[k] = 0;

        #23;
        check("rst_in_ready", longint'(in_ready_o), 1);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_out_valid", longint'(out_valid_o), 0);
        check("rst_out_data", longint'(out_data_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        chk_gap = 1'b1;
        for (int r = 0; r < 10; r++) begin
            if (tbl[r].cset == 1) load_ramp();
            else if (tbl[r].cset == 2) load_const(-128);
            model_shift(tbl[r].smp);
            exp_q.push_back(longint'(tbl[r].e0));
            exp_q.push_back(longint'(tbl[r].e1));
            exp_q.push_back(longint'(tbl[r].e2));
            exp_q.push_back(longint'(tbl[r].e3));
            send(tbl[r].smp, 1'b0, 0, 0);
            drain();
        end
        chk_gap = 1'b0;

        // Backpressure on the first phase output.
        out_ready_i = 1'b0;
        model_shift(5);
        push_model();
        send(5, 1'b0, 0, 0);
        begin
            int n = 0;
            while (!out_valid_o && n < 50) begin
                @(negedge clk_i);
                n++;
            end
        end
        check("bp_valid_timeout", longint'(out_valid_o), 1);
        held = out_data_o;
        check("bp_first_value", longint'($signed(out_data_o)), exp_q[0]);
        repeat (2) begin
            @(negedge clk_i);
            check("bp_valid_hold", longint'(out_valid_o), 1);
            check("bp_data_hold", longint'(out_data_o), longint'(held));
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_release", longint'(out_valid_o), 0);
        drain();

        // Coefficient write during MAC is dropped; the same write in IDLE lands.
        model_shift(1);
        push_model();
        send(1, 1'b0, 0, 0);
        @(posedge clk_i); #1;
        check("busy_in_mac", longint'(busy_o), 1);
        wr_coef(0, 99, 1'b0);
        drain();
        wr_coef(0, 99, 1'b1);
        model_shift(1);
        push_model();
        send(1, 1'b0, 0, 0);
        drain();

        // Write and sample accept on the same edge: the new coefficient is used.
        h_m[3] = -20;
        model_shift(-2);
        push_model();
        send(-2, 1'b1, 3, -20);
        drain();

        // Reset during the MAC of phase 2 discards everything.
        model_shift(3);
        push_model();
        send(3, 1'b0, 0, 0);
        begin
            int base = n_out - 0;
            int n = 0;
            base = n_out;
            while (n_out < base + 2 && n < 100) begin
                @(posedge clk_i); #1;
                n++;
            end
            check("midrst_wait_timeout", longint'(n_out - base), 2);
        end
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        check("midrst_in_ready", longint'(in_ready_o), 1);
        check("midrst_busy", longint'(busy_o), 0);
        check("midrst_out_valid", longint'(out_valid_o), 0);
        check("midrst_out_data", longint'(out_data_o), 0);
        exp_q.delete();
        for (int i = 0; i < P; i++) dl_m[i] = 0;
        for (int k = 0; k < NCOEF; k++) h_m[k] = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        begin
            int seen = 0;
            repeat (20) begin
                @(negedge clk_i);
                if (out_valid_o) seen++;
            end
            check("post_reset_quiet", longint'(seen), 0);
        end
        @(posedge clk_i); #1;
        load_ramp();
        model_shift(0);
        push_model();
        send(0, 1'b0, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
